// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
//   Bundles the functional-unit completion requests and the common data bus
//   broadcast slots that pass through the CDB arbiter.
//
//   Functional-unit side (driven by the units, read by the arbiter):
//     fu_valid, fu_value, fu_dest_prf, fu_rob_entry, fu_value_valid
//   Arbiter -> units:
//     fu_sel            combinational grant, one bit per unit
//   Arbiter -> CDB consumers (registered):
//     cdb_valid, cdb_value, cdb_dest_prf, cdb_rob_entry, cdb_value_valid
//
//   Modports:
//     slave  - the arbiter itself
//     master - the units / CDB consumers (or a testbench standing in for them)
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int NUM_FU    = 8,
  parameter int CDB_WIDTH = 2,
  parameter int XLEN      = 32,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5
);
  logic [NUM_FU-1:0]              fu_valid;
  logic [NUM_FU*XLEN-1:0]         fu_value;
  logic [NUM_FU*PRF_IDX_W-1:0]    fu_dest_prf;
  logic [NUM_FU*ROB_IDX_W-1:0]    fu_rob_entry;
  logic [NUM_FU-1:0]              fu_value_valid;
  logic [NUM_FU-1:0]              fu_sel;

  logic [CDB_WIDTH-1:0]           cdb_valid;
  logic [CDB_WIDTH*XLEN-1:0]      cdb_value;
  logic [CDB_WIDTH*PRF_IDX_W-1:0] cdb_dest_prf;
  logic [CDB_WIDTH*ROB_IDX_W-1:0] cdb_rob_entry;
  logic [CDB_WIDTH-1:0]           cdb_value_valid;

  modport slave (
    input  fu_valid, fu_value, fu_dest_prf, fu_rob_entry, fu_value_valid,
    output fu_sel,
    output cdb_valid, cdb_value, cdb_dest_prf, cdb_rob_entry, cdb_value_valid
  );

  modport master (
    output fu_valid, fu_value, fu_dest_prf, fu_rob_entry, fu_value_valid,
    input  fu_sel,
    input  cdb_valid, cdb_value, cdb_dest_prf, cdb_rob_entry, cdb_value_valid
  );
endinterface

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//   Completion-stage arbiter between NUM_FU functional units and a common
//   data bus with CDB_WIDTH broadcast slots. Each cycle the first CDB_WIDTH
//   valid units found scanning round-robin from rr_ptr are granted (fu_sel,
//   combinational) and their results are registered onto the CDB slots, so a
//   grant at cycle t is broadcast at t+1. The k-th granted unit goes to
//   slot k. squash suppresses all grants and empties the next broadcast.
//
//   Ports:
//     clock   - clock, all state on posedge
//     reset   - synchronous, active-high; clears rr_ptr and the CDB slots
//     squash  - mispredict flush: no grants now, empty CDB next cycle
//     bus     - cdb_arbiter_if.slave (unit requests, fu_sel, CDB slots)
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_FU    = 8,
  parameter int CDB_WIDTH = 2,
  parameter int XLEN      = 32,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         squash,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]               rr_ptr;
  logic [PTR_W-1:0]               next_ptr;
  logic [NUM_FU-1:0]              sel;
  logic [CDB_WIDTH-1:0]           slot_hit;
  logic [PTR_W-1:0]               slot_idx [CDB_WIDTH];
  int                             found;
  int                             idx;

  logic [CDB_WIDTH-1:0]           cdb_valid_p1;
  logic [CDB_WIDTH*XLEN-1:0]      cdb_value_p1;
  logic [CDB_WIDTH*PRF_IDX_W-1:0] cdb_dest_prf_p1;
  logic [CDB_WIDTH*ROB_IDX_W-1:0] cdb_rob_entry_p1;
  logic [CDB_WIDTH-1:0]           cdb_value_valid_p1;

  // Stage 0: combinational round-robin grant. The scan visits every unit once
  // starting at rr_ptr; the pointer advances to just past the last grant so
  // the next cycle starts with the first unit that lost (or was not asking).
  always_comb begin
    sel      = '0;
    slot_hit = '0;
    next_ptr = rr_ptr;
    found    = 0;
    idx      = 0;
    for (int k = 0; k < CDB_WIDTH; k++) slot_idx[k] = '0;
    if (!reset && !squash) begin
      for (int j = 0; j < NUM_FU; j++) begin
        idx = (int'(rr_ptr) + j) % NUM_FU;
        if (bus.fu_valid[idx] && found < CDB_WIDTH) begin
          sel[idx]        = 1'b1;
          slot_hit[found] = 1'b1;
          slot_idx[found] = PTR_W'(idx);
          next_ptr        = PTR_W'((idx + 1) % NUM_FU);
          found++;
        end
      end
    end
  end

  assign bus.fu_sel = sel;

  // Stage 1: CDB broadcast registers. Ungranted slots are zeroed so no stale
  // tag can ever be seen alongside a low valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr             <= '0;
      cdb_valid_p1       <= '0;
      cdb_value_p1       <= '0;
      cdb_dest_prf_p1    <= '0;
      cdb_rob_entry_p1   <= '0;
      cdb_value_valid_p1 <= '0;
    end else begin
      if (!squash && slot_hit[0]) rr_ptr <= next_ptr;
      for (int k = 0; k < CDB_WIDTH; k++) begin
        cdb_valid_p1[k] <= slot_hit[k];
        if (slot_hit[k]) begin
          cdb_value_p1[k*XLEN +: XLEN]            <= bus.fu_value[int'(slot_idx[k])*XLEN +: XLEN];
          cdb_dest_prf_p1[k*PRF_IDX_W +: PRF_IDX_W] <= bus.fu_dest_prf[int'(slot_idx[k])*PRF_IDX_W +: PRF_IDX_W];
          cdb_rob_entry_p1[k*ROB_IDX_W +: ROB_IDX_W] <= bus.fu_rob_entry[int'(slot_idx[k])*ROB_IDX_W +: ROB_IDX_W];
          cdb_value_valid_p1[k]                  <= bus.fu_value_valid[slot_idx[k]];
        end else begin
          cdb_value_p1[k*XLEN +: XLEN]            <= '0;
          cdb_dest_prf_p1[k*PRF_IDX_W +: PRF_IDX_W] <= '0;
          cdb_rob_entry_p1[k*ROB_IDX_W +: ROB_IDX_W] <= '0;
          cdb_value_valid_p1[k]                  <= 1'b0;
        end
      end
    end
  end

  assign bus.cdb_valid       = cdb_valid_p1;
  assign bus.cdb_value       = cdb_value_p1;
  assign bus.cdb_dest_prf    = cdb_dest_prf_p1;
  assign bus.cdb_rob_entry   = cdb_rob_entry_p1;
  assign bus.cdb_value_valid = cdb_value_valid_p1;

endmodule
